// File: rtl/ascon_stream_ctrl.sv
// ============================================================================
// Module   : ascon_stream_ctrl
// Purpose  : Streaming sequencer for the single-core ASCON AEAD datapath.
//            Optional 2-entry ciphertext FIFO: define ASCON_CT_SKID_EN.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module ascon_stream_ctrl #(
    parameter int MAX_BLOCKS     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic         clock_i,
    input  logic         reset_i,
    input  logic         start_i,
    input  logic [127:0] key_i,
    input  logic [127:0] nonce_i,
    input  logic [63:0]  ad_i,
    input  logic [63:0]  msg_data_i,
    input  logic         msg_valid_i,
    input  logic         msg_last_i,
    output logic         msg_ready_o,
    output logic [63:0]  ct_data_o,
    output logic         ct_valid_o,
    output logic         ct_last_o,
    input  logic         ct_ready_i,
    output logic [127:0] tag_o,
    output logic         done_o,
    output logic         busy_o,
    output logic         error_o,
    output logic [7:0]   block_count_o,
    output logic         core_init_o,
    output logic         core_associate_data_o,
    output logic         core_finalisation_o,
    output logic         core_data_valid_o,
    output logic [63:0]  core_data_o,
    output logic [127:0] core_key_o,
    output logic [127:0] core_nonce_o,
    input  logic         core_end_initialisation_i,
    input  logic         core_end_associate_i,
    input  logic         core_cipher_valid_i,
    input  logic         core_end_cipher_i,
    input  logic         core_end_tag_i,
    input  logic [63:0]  core_cipher_i,
    input  logic [127:0] core_tag_i
);

    localparam int               C_WD_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [C_WD_W-1:0] C_WD_LAST = C_WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [C_WD_W-1:0] C_WD_ONE  = C_WD_W'(1);
    localparam logic [7:0]        C_BLK_LAST = 8'(MAX_BLOCKS - 1);

    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_INIT       = 4'd1,
        S_INIT_WAIT  = 4'd2,
        S_AD         = 4'd3,
        S_AD_WAIT    = 4'd4,
        S_MSG_WAIT   = 4'd5,
        S_MSG_SEND   = 4'd6,
        S_MSG_RUN    = 4'd7,
        S_FINAL_SEND = 4'd8,
        S_FINAL_RUN  = 4'd9,
        S_DRAIN      = 4'd10,
        S_DONE       = 4'd11,
        S_ERROR      = 4'd12
    } state_e;

    state_e              state_q, state_d;
    logic [127:0]        key_q, key_d;
    logic [127:0]        nonce_q, nonce_d;
    logic [63:0]         ad_q, ad_d;
    logic [63:0]         msg_q, msg_d;
    logic [7:0]          count_q, count_d;
    logic [127:0]        tag_q, tag_d;
    logic                error_q, error_d;
    logic [C_WD_W-1:0]   wdog_q, wdog_d;

    logic                w_start_acc;
    logic                w_msg_hs;
    logic                w_push;
    logic                w_push_last;
    logic                w_tag_en;
    logic                w_pop;
    logic                w_flush;
    logic                w_buf_room;
    logic                w_buf_any;
    logic [64:0]         w_push_ent;
    logic [64:0]         w_head;
    logic                w_wd_active;
    logic                w_wd_expired;

    assign w_wd_active  = (state_q == S_INIT_WAIT) || (state_q == S_AD_WAIT) ||
                          (state_q == S_MSG_RUN)   || (state_q == S_FINAL_RUN);
    assign w_wd_expired = w_wd_active && (wdog_q == C_WD_LAST);

    // FSM next-state and handshake decode
    always_comb begin
        state_d     = state_q;
        w_start_acc = 1'b0;
        w_msg_hs    = 1'b0;
        w_push      = 1'b0;
        w_push_last = 1'b0;
        w_tag_en    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    w_start_acc = 1'b1;
                    state_d     = S_INIT;
                end
            end
            S_INIT:      state_d = S_INIT_WAIT;
            S_INIT_WAIT: begin
                if (core_end_initialisation_i) state_d = S_AD;
                else if (w_wd_expired)         state_d = S_ERROR;
            end
            S_AD:        state_d = S_AD_WAIT;
            S_AD_WAIT: begin
                if (core_end_associate_i) state_d = S_MSG_WAIT;
                else if (w_wd_expired)    state_d = S_ERROR;
            end
            S_MSG_WAIT: begin
                if (msg_valid_i && w_buf_room) begin
                    w_msg_hs = 1'b1;
                    if (msg_last_i)                  state_d = S_FINAL_SEND;
                    else if (count_q >= C_BLK_LAST)  state_d = S_ERROR;
                    else                             state_d = S_MSG_SEND;
                end
            end
            S_MSG_SEND:  state_d = S_MSG_RUN;
            S_MSG_RUN: begin
                w_push = core_cipher_valid_i;
                if (core_end_cipher_i) state_d = S_MSG_WAIT;
                else if (w_wd_expired) state_d = S_ERROR;
            end
            S_FINAL_SEND: state_d = S_FINAL_RUN;
            S_FINAL_RUN: begin
                w_push      = core_cipher_valid_i;
                w_push_last = 1'b1;
                if (core_end_tag_i) begin
                    w_tag_en = 1'b1;
                    state_d  = S_DRAIN;
                end else if (w_wd_expired) begin
                    state_d = S_ERROR;
                end
            end
            S_DRAIN: begin
                if (!w_buf_any) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            S_ERROR: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Watchdog restarts on every state change and idles outside the wait states
    assign wdog_d = (w_wd_active && (state_d == state_q)) ? (wdog_q + C_WD_ONE) : '0;

    always_comb begin
        key_d   = key_q;
        nonce_d = nonce_q;
        ad_d    = ad_q;
        msg_d   = msg_q;
        count_d = count_q;
        tag_d   = tag_q;
        error_d = error_q;
        if (w_start_acc) begin
            key_d   = key_i;
            nonce_d = nonce_i;
            ad_d    = ad_i;
            count_d = '0;
            tag_d   = '0;
            error_d = 1'b0;
        end
        if (w_msg_hs) begin
            msg_d   = msg_data_i;
            count_d = count_q + 8'd1;
        end
        if (w_tag_en) tag_d = core_tag_i;
        if (state_d == S_ERROR) error_d = 1'b1;
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            key_q   <= '0;
            nonce_q <= '0;
            ad_q    <= '0;
            msg_q   <= '0;
            count_q <= '0;
            tag_q   <= '0;
            error_q <= 1'b0;
            wdog_q  <= '0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            nonce_q <= nonce_d;
            ad_q    <= ad_d;
            msg_q   <= msg_d;
            count_q <= count_d;
            tag_q   <= tag_d;
            error_q <= error_d;
            wdog_q  <= wdog_d;
        end
    end

    assign w_push_ent = {w_push_last, core_cipher_i};
    assign w_pop      = w_buf_any && ct_ready_i;
    assign w_flush    = (state_d == S_ERROR);

`ifdef ASCON_CT_SKID_EN
    logic [1:0]  fill_q, fill_d;
    logic [64:0] ent0_q, ent0_d;
    logic [64:0] ent1_q, ent1_d;

    // Entry 0 is always the head; entry 1 shifts down on a pop
    always_comb begin
        fill_d = fill_q;
        ent0_d = ent0_q;
        ent1_d = ent1_q;
        case ({w_push, w_pop})
            2'b01: begin
                ent0_d = ent1_q;
                fill_d = fill_q - 2'd1;
            end
            2'b10: begin
                if (fill_q == 2'd0) ent0_d = w_push_ent;
                else                ent1_d = w_push_ent;
                fill_d = fill_q + 2'd1;
            end
            2'b11: begin
                if (fill_q == 2'd1) begin
                    ent0_d = w_push_ent;
                end else begin
                    ent0_d = ent1_q;
                    ent1_d = w_push_ent;
                end
            end
            default: ;
        endcase
        if (w_flush) fill_d = 2'd0;
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            fill_q <= 2'd0;
            ent0_q <= '0;
            ent1_q <= '0;
        end else begin
            fill_q <= fill_d;
            ent0_q <= ent0_d;
            ent1_q <= ent1_d;
        end
    end

    assign w_buf_any  = (fill_q != 2'd0);
    assign w_buf_room = (fill_q != 2'd2);
    assign w_head     = ent0_q;
`else
    logic        buf_valid_q, buf_valid_d;
    logic [64:0] buf_ent_q, buf_ent_d;

    always_comb begin
        buf_valid_d = buf_valid_q;
        buf_ent_d   = buf_ent_q;
        if (w_pop) buf_valid_d = 1'b0;
        if (w_push) begin
            buf_valid_d = 1'b1;
            buf_ent_d   = w_push_ent;
        end
        if (w_flush) buf_valid_d = 1'b0;
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            buf_valid_q <= 1'b0;
            buf_ent_q   <= '0;
        end else begin
            buf_valid_q <= buf_valid_d;
            buf_ent_q   <= buf_ent_d;
        end
    end

    assign w_buf_any  = buf_valid_q;
    assign w_buf_room = !buf_valid_q;
    assign w_head     = buf_ent_q;
`endif

    assign msg_ready_o           = (state_q == S_MSG_WAIT) && w_buf_room;
    assign ct_valid_o            = w_buf_any;
    assign ct_data_o             = w_buf_any ? w_head[63:0] : 64'd0;
    assign ct_last_o             = w_buf_any && w_head[64];
    assign tag_o                 = tag_q;
    assign done_o                = (state_q == S_DONE);
    assign busy_o                = (state_q != S_IDLE);
    assign error_o               = error_q;
    assign block_count_o         = count_q;
    assign core_init_o           = (state_q == S_INIT);
    assign core_associate_data_o = (state_q == S_AD);
    assign core_finalisation_o   = (state_q == S_FINAL_SEND) || (state_q == S_FINAL_RUN);
    assign core_data_valid_o     = (state_q == S_AD) || (state_q == S_MSG_SEND) ||
                                   (state_q == S_FINAL_SEND);
    assign core_data_o           = (state_q == S_AD) ? ad_q :
                                   ((state_q == S_MSG_SEND) || (state_q == S_FINAL_SEND)) ?
                                   msg_q : 64'd0;
    assign core_key_o            = key_q;
    assign core_nonce_o          = nonce_q;

endmodule

`default_nettype wire

// File: tb/tb_ascon_stream_ctrl.sv
// ============================================================================
// Module   : tb_ascon_stream_ctrl
// Purpose  : Directed scoreboard bench for ascon_stream_ctrl with a core model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ascon_stream_ctrl;

    logic         clock_i = 1'b0;
    logic         reset_i;
    logic         start_i;
    logic [127:0] key_i;
    logic [127:0] nonce_i;
    logic [63:0]  ad_i;
    logic [63:0]  msg_data_i;
    logic         msg_valid_i;
    logic         msg_last_i;
    logic         msg_ready_o;
    logic [63:0]  ct_data_o;
    logic         ct_valid_o;
    logic         ct_last_o;
    logic         ct_ready_i;
    logic [127:0] tag_o;
    logic         done_o;
    logic         busy_o;
    logic         error_o;
    logic [7:0]   block_count_o;
    logic         core_init_o;
    logic         core_associate_data_o;
    logic         core_finalisation_o;
    logic         core_data_valid_o;
    logic [63:0]  core_data_o;
    logic [127:0] core_key_o;
    logic [127:0] core_nonce_o;
    logic         core_end_initialisation_i = 1'b0;
    logic         core_end_associate_i = 1'b0;
    logic         core_cipher_valid_i = 1'b0;
    logic         core_end_cipher_i = 1'b0;
    logic         core_end_tag_i = 1'b0;
    logic [63:0]  core_cipher_i = '0;
    logic [127:0] core_tag_i = '0;

    always #5 clock_i = ~clock_i;

    ascon_stream_ctrl #(.MAX_BLOCKS(4), .TIMEOUT_CYCLES(255)) dut (
        .clock_i(clock_i), .reset_i(reset_i), .start_i(start_i),
        .key_i(key_i), .nonce_i(nonce_i), .ad_i(ad_i),
        .msg_data_i(msg_data_i), .msg_valid_i(msg_valid_i), .msg_last_i(msg_last_i),
        .msg_ready_o(msg_ready_o), .ct_data_o(ct_data_o), .ct_valid_o(ct_valid_o),
        .ct_last_o(ct_last_o), .ct_ready_i(ct_ready_i), .tag_o(tag_o),
        .done_o(done_o), .busy_o(busy_o), .error_o(error_o),
        .block_count_o(block_count_o), .core_init_o(core_init_o),
        .core_associate_data_o(core_associate_data_o),
        .core_finalisation_o(core_finalisation_o),
        .core_data_valid_o(core_data_valid_o), .core_data_o(core_data_o),
        .core_key_o(core_key_o), .core_nonce_o(core_nonce_o),
        .core_end_initialisation_i(core_end_initialisation_i),
        .core_end_associate_i(core_end_associate_i),
        .core_cipher_valid_i(core_cipher_valid_i),
        .core_end_cipher_i(core_end_cipher_i), .core_end_tag_i(core_end_tag_i),
        .core_cipher_i(core_cipher_i), .core_tag_i(core_tag_i)
    );

    int           n_cmp = 0;
    int           n_fail = 0;
    logic [64:0]  exp_q[$];
    logic [64:0]  sb_e;
    logic [127:0] cur_key;
    int           n_init = 0, n_done = 0, n_send = 0, n_fin = 0, n_finrun = 0;
    bit           tag_enable = 1'b1;
    int           p_init = -1, p_ad = -1, p_dat = -1;
    logic [63:0]  lat_data = '0;
    logic         lat_fin = 1'b0;

    task automatic check(input string tag, input logic [639:0] obs, input logic [639:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [639:0] all_outs();
        return {108'd0, msg_ready_o, ct_data_o, ct_valid_o, ct_last_o, tag_o, done_o,
                busy_o, error_o, block_count_o, core_init_o, core_associate_data_o,
                core_finalisation_o, core_data_valid_o, core_data_o, core_key_o,
                core_nonce_o};
    endfunction

    // Core model: answers each control pulse after a short latency.
    always @(negedge clock_i) begin
        core_end_initialisation_i = 1'b0;
        core_end_associate_i      = 1'b0;
        core_cipher_valid_i       = 1'b0;
        core_end_cipher_i         = 1'b0;
        core_end_tag_i            = 1'b0;
        core_cipher_i             = '0;
        core_tag_i                = '0;
        if (reset_i) begin
            p_init = -1;
            p_ad   = -1;
            p_dat  = -1;
        end else begin
            if (p_init == 0) core_end_initialisation_i = 1'b1;
            if (p_init >= 0) p_init--;
            if (p_ad == 0) core_end_associate_i = 1'b1;
            if (p_ad >= 0) p_ad--;
            if (p_dat == 0) begin
                core_cipher_valid_i = 1'b1;
                core_cipher_i       = lat_data ^ core_key_o[63:0];
                if (lat_fin) begin
                    core_end_tag_i = tag_enable;
                    core_tag_i     = core_key_o ^ core_nonce_o;
                end else begin
                    core_end_cipher_i = 1'b1;
                end
            end
            if (p_dat >= 0) p_dat--;
            if (core_init_o) begin
                p_init = 2;
                n_init++;
            end
            if (core_associate_data_o) begin
                p_ad = 1;
            end else if (core_data_valid_o) begin
                lat_data = core_data_o;
                lat_fin  = core_finalisation_o;
                p_dat    = 2;
                if (!core_finalisation_o) n_send++;
            end
            if (core_finalisation_o) n_fin++;
            if (core_finalisation_o && !core_data_valid_o) n_finrun++;
            if (done_o) n_done++;
            if (!core_data_valid_o) check("core_data_idle_zero", core_data_o, 0);
        end
    end

    // Ciphertext sink: pops the expected beat on every handshake.
    always @(negedge clock_i) begin
        if (!reset_i && ct_valid_o && ct_ready_i) begin
            check("ct_expected_present", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                sb_e = exp_q.pop_front();
                check("ct_data", ct_data_o, sb_e[63:0]);
                check("ct_last", ct_last_o, sb_e[64]);
            end
        end
    end

    task automatic start_op(input logic [127:0] k, input logic [127:0] n, input logic [63:0] a);
        key_i   = k;
        nonce_i = n;
        ad_i    = a;
        cur_key = k;
        start_i = 1'b1;
        @(posedge clock_i); #1;
        start_i = 1'b0;
        @(negedge clock_i);
        check("init_latency", core_init_o, 1);
        check("start_clears_error", error_o, 0);
        check("start_clears_tag", tag_o, 0);
        check("start_clears_count", block_count_o, 0);
        check("core_key_registered", core_key_o, k);
        @(posedge clock_i); #1;
        key_i   = ~k;
        nonce_i = ~n;
    endtask

    task automatic send_beat(input logic [63:0] d, input logic last, input bit exp_ct);
        int n = 0;
        msg_data_i  = d;
        msg_last_i  = last;
        msg_valid_i = 1'b1;
        @(negedge clock_i);
        while (!msg_ready_o && n < 500) begin
            n++;
            @(negedge clock_i);
        end
        check("msg_accept", msg_ready_o, 1);
        if (msg_ready_o && exp_ct) exp_q.push_back({last, d ^ cur_key[63:0]});
        @(posedge clock_i); #1;
        msg_valid_i = 1'b0;
        msg_data_i  = '0;
        msg_last_i  = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        @(negedge clock_i);
        while (!done_o && !error_o && n < 2000) begin
            n++;
            @(negedge clock_i);
        end
        check("done_seen", done_o, 1);
        @(posedge clock_i); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench did not finish");
    end

    initial begin
        int d0, i0, s0, n;
        reset_i = 1'b1; start_i = 1'b0; key_i = '0; nonce_i = '0; ad_i = '0;
        msg_data_i = '0; msg_valid_i = 1'b0; msg_last_i = 1'b0; ct_ready_i = 1'b1;
        repeat (2) @(posedge clock_i);
        @(negedge clock_i);
        check("reset_outputs_zero", all_outs(), 0);
        @(posedge clock_i); #1;
        reset_i = 1'b0;

        // Three-beat message, start pulse while busy must be ignored
        d0 = n_done; i0 = n_init;
        start_op(128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF,
                 128'h0F0E_0D0C_0B0A_0908_0706_0504_0302_0100, 64'hA0A1_A2A3_A4A5_A6A7);
        send_beat(64'd1, 1'b0, 1'b1);
        start_i = 1'b1;
        @(posedge clock_i); #1;
        start_i = 1'b0;
        send_beat(64'd2, 1'b0, 1'b1);
        send_beat(64'd3, 1'b1, 1'b1);
        wait_done();
        check("t1_tag", tag_o, 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF ^
                               128'h0F0E_0D0C_0B0A_0908_0706_0504_0302_0100);
        check("t1_block_count", block_count_o, 3);
        repeat (2) @(posedge clock_i); #1;
        check("t1_done_once", n_done - d0, 1);
        check("t1_single_init", n_init - i0, 1);
        check("t1_idle", busy_o, 0);
        check("t1_ct_drained", exp_q.size(), 0);

        // Single-beat message goes straight to finalisation
        d0 = n_done; s0 = n_send; n_fin = 0;
        start_op(128'hDEAD_0000_BEEF_0000_1234_5678_9ABC_DEF0,
                 128'h1111_2222_3333_4444_5555_6666_7777_8888, 64'h5A5A_5A5A_5A5A_5A5A);
        send_beat(64'hDEADBEEF_00000000, 1'b1, 1'b1);
        wait_done();
        check("t2_no_msg_send", n_send - s0, 0);
        check("t2_final_seen", n_fin >= 2, 1);
        check("t2_block_count", block_count_o, 1);
        check("t2_tag", tag_o, 128'hDEAD_0000_BEEF_0000_1234_5678_9ABC_DEF0 ^
                               128'h1111_2222_3333_4444_5555_6666_7777_8888);
        repeat (2) @(posedge clock_i); #1;
        check("t2_done_once", n_done - d0, 1);
        check("t2_ct_drained", exp_q.size(), 0);

        // Ciphertext sink stalls for 20 cycles
        ct_ready_i = 1'b0;
        start_op(128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210,
                 128'hCAFE_F00D_CAFE_F00D_CAFE_F00D_CAFE_F00D, 64'h1);
        send_beat(64'h11, 1'b0, 1'b1);
        n = 0;
        @(negedge clock_i);
        while (!ct_valid_o && n < 100) begin
            n++;
            @(negedge clock_i);
        end
        check("t3_ct_appears", ct_valid_o, 1);
        msg_data_i = 64'h22; msg_last_i = 1'b0; msg_valid_i = 1'b1;
        repeat (20) begin
            @(negedge clock_i);
            check("t3_ct_stable", ct_data_o, 64'h11 ^ 64'hFEDC_BA98_7654_3210);
            check("t3_msg_blocked", msg_ready_o, 0);
        end
        @(posedge clock_i); #1;
        ct_ready_i = 1'b1;
        send_beat(64'h22, 1'b0, 1'b1);
        send_beat(64'h33, 1'b1, 1'b1);
        wait_done();
        check("t3_block_count", block_count_o, 3);
        check("t3_ct_drained", exp_q.size(), 0);

        // Core never signals end of tag: watchdog error
        d0 = n_done;
        tag_enable = 1'b0;
        start_op(128'h5555_AAAA_5555_AAAA_5555_AAAA_5555_AAAA,
                 128'h0, 64'h2);
        n_finrun = 0;
        send_beat(64'h44, 1'b1, 1'b1);
        n = 0;
        @(negedge clock_i);
        while (!error_o && n < 400) begin
            n++;
            @(negedge clock_i);
        end
        check("t4_timeout_error", error_o, 1);
        check("t4_timeout_cycles", n_finrun, 255);
        @(posedge clock_i); #1;
        @(negedge clock_i);
        check("t4_back_to_idle", busy_o, 0);
        check("t4_error_sticky", error_o, 1);
        check("t4_no_done", n_done - d0, 0);
        check("t4_ct_drained", exp_q.size(), 0);
        @(posedge clock_i); #1;
        tag_enable = 1'b1;
        start_op(128'h7777_0000_7777_0000_7777_0000_7777_0000,
                 128'h0000_9999_0000_9999_0000_9999_0000_9999, 64'h3);
        send_beat(64'h45, 1'b1, 1'b1);
        wait_done();
        check("t4_recover_tag", tag_o, 128'h7777_9999_7777_9999_7777_9999_7777_9999);

        // Overflow: four non-last beats with MAX_BLOCKS = 4
        d0 = n_done;
        start_op(128'h8888_1111_8888_1111_8888_1111_8888_1111,
                 128'h4, 64'h4);
        send_beat(64'h51, 1'b0, 1'b1);
        send_beat(64'h52, 1'b0, 1'b1);
        send_beat(64'h53, 1'b0, 1'b1);
        send_beat(64'h54, 1'b0, 1'b0);
        @(negedge clock_i);
        check("t5_overflow_error", error_o, 1);
        check("t5_block_count", block_count_o, 4);
        @(posedge clock_i); #1;
        msg_data_i = 64'h55; msg_valid_i = 1'b1; msg_last_i = 1'b0;
        repeat (3) begin
            @(negedge clock_i);
            check("t5_fifth_not_taken", msg_ready_o, 0);
        end
        @(posedge clock_i); #1;
        msg_valid_i = 1'b0;
        check("t5_no_done", n_done - d0, 0);
        check("t5_idle", busy_o, 0);
        check("t5_ct_drained", exp_q.size(), 0);

        // Reset asserted while the core processes a message block
        start_op(128'h9999_8888_7777_6666_5555_4444_3333_2222,
                 128'h6, 64'h6);
        send_beat(64'h61, 1'b0, 1'b1);
        @(posedge clock_i); #1;
        check("t6_in_msg_run", {core_data_valid_o, busy_o}, 2'b01);
        reset_i = 1'b1;
        #1;
        check("t6_reset_outputs_zero", all_outs(), 0);
        exp_q.delete();
        @(negedge clock_i);
        @(posedge clock_i); #1;
        reset_i = 1'b0;
        d0 = n_done;
        start_op(128'hABCD_EF01_2345_6789_ABCD_EF01_2345_6789,
                 128'h1357_9BDF_2468_ACE0_1357_9BDF_2468_ACE0, 64'h7);
        send_beat(64'h62, 1'b1, 1'b1);
        wait_done();
        check("t6_tag", tag_o, 128'hABCD_EF01_2345_6789_ABCD_EF01_2345_6789 ^
                               128'h1357_9BDF_2468_ACE0_1357_9BDF_2468_ACE0);
        repeat (2) @(posedge clock_i); #1;
        check("t6_done_once", n_done - d0, 1);
        check("t6_ct_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ascon_stream_ctrl.md
Name: ascon_stream_ctrl

Overview:
- Streaming sequencer for the single-core ASCON AEAD datapath.
- Accepts a variable-length message as 64-bit valid/ready beats with a last flag, and drives the core through four phases: initialisation, one associated-data block, message blocks, finalisation.
- Returns ciphertext beats on a valid/ready stream and a registered 128-bit tag.
- Replaces fixed-length, fully-parallel plaintext handling in the top level and sits between the host interface and the ascon core.

Parameters:
MAX_BLOCKS, 32, maximum message beats per operation including the last one (range 1..255).
TIMEOUT_CYCLES, 255, watchdog limit in cycles while waiting on any core status flag.

Ports:
clock_i  in  1  clock
reset_i  in  1  asynchronous, active-high reset
start_i  in  1  start request; sampled only in IDLE
key_i  in  128  key; registered on start accept
nonce_i  in  128  nonce; registered on start accept
ad_i  in  64  associated-data block; registered on start accept
msg_data_i  in  64  plaintext beat
msg_valid_i  in  1  plaintext beat valid
msg_last_i  in  1  marks the final plaintext beat
msg_ready_o  out  1  plaintext beat accepted when valid&ready
ct_data_o  out  64  ciphertext beat
ct_valid_o  out  1  ciphertext beat valid
ct_last_o  out  1  final ciphertext beat
ct_ready_i  in  1  ciphertext sink ready
tag_o  out  128  tag; held until next start accept
done_o  out  1  one-cycle completion pulse
busy_o  out  1  high in every state except IDLE
error_o  out  1  sticky watchdog/overflow error
block_count_o  out  8  message beats accepted in current operation
core_init_o, core_associate_data_o, core_finalisation_o, core_data_valid_o  out  1 each  core controls
core_data_o  out  64  core data input
core_key_o, core_nonce_o  out  128 each  registered key/nonce
core_end_initialisation_i, core_end_associate_i, core_cipher_valid_i, core_end_cipher_i, core_end_tag_i  in  1 each  core status
core_cipher_i  in  64  core ciphertext
core_tag_i  in  128  core tag

Behaviour:
- Reset: all outputs 0, FSM in IDLE, counters 0, ciphertext buffer empty.
- FSM states and transitions:
  - IDLE → INIT on start_i; registers key/nonce/ad, clears error_o, block_count_o and tag_o.
  - INIT: core_init_o pulses 1 cycle → INIT_WAIT.
  - INIT_WAIT → AD on core_end_initialisation_i.
  - AD: core_associate_data_o=core_data_valid_o=1 for 1 cycle, core_data_o=ad → AD_WAIT.
  - AD_WAIT → MSG_WAIT on core_end_associate_i.
  - MSG_WAIT: msg_ready_o=1 iff the ciphertext buffer is empty. On handshake, latch the beat and increment block_count_o.
    - last=0 → MSG_SEND.
    - last=1 → FINAL_SEND.
  - MSG_SEND: core_data_valid_o pulse with the latched beat → MSG_RUN.
  - MSG_RUN: capture core_cipher_i into the buffer on core_cipher_valid_i; → MSG_WAIT on core_end_cipher_i.
  - FINAL_SEND: core_finalisation_o=1 and core_data_valid_o pulse → FINAL_RUN.
  - FINAL_RUN: core_finalisation_o held high; capture the cipher (marked last) on core_cipher_valid_i; on core_end_tag_i register core_tag_i → DRAIN.
  - DRAIN → DONE when the buffer is empty.
  - DONE: done_o=1 for 1 cycle → IDLE.
- Core control: core_data_o=0 whenever core_data_valid_o=0. Latency from start accept edge to core_init_o high is 1 cycle.
- Ciphertext buffer: single entry; ct_valid_o=1 while occupied, held stable until ct_ready_i. ct_last_o=1 only for the finalisation block.
- Watchdog: counts cycles in INIT_WAIT, AD_WAIT, MSG_RUN and FINAL_RUN; clears on each state change. Reaching TIMEOUT_CYCLES → ERROR.
- Overflow: a handshake with block_count reaching MAX_BLOCKS and msg_last_i=0 → ERROR; the beat is consumed.
- ERROR: error_o=1 (sticky until the next start accept), buffer flushed, no done_o → IDLE next cycle.
- Boundary conditions:
  - start_i while busy is ignored.
  - msg_valid_i with msg_ready_o=0 is not consumed.
  - A single-beat message (last on the first beat) skips MSG_SEND.
  - Reset mid-operation returns to IDLE immediately with all outputs 0.

Optional Feature:
- ASCON_CT_SKID_EN defined: the ciphertext buffer becomes a 2-entry FIFO. msg_ready_o=1 in MSG_WAIT while fewer than 2 entries are occupied, and beats leave in order.
- Not defined: single-entry buffer as above.

Test Plan:
- Start; 3 beats 0x0..01, 0x0..02, 0x0..03 (last on the third); ct_ready_i=1 → 3 ct beats, ct_last_o only on the 3rd, tag_o=core_tag_i, done_o 1 cycle, block_count_o=3.
- Single beat 0xDEADBEEF_00000000 with last=1 → core_finalisation_o high, no MSG_SEND pulse, 1 ct beat with last, done_o.
- ct_ready_i held 0 for 20 cycles after the first ct → ct_data_o stable, msg_ready_o=0; the flow resumes after ready.
- Core model never raises end_tag → error_o=1 after 255 cycles, FSM in IDLE, no done_o; the next start clears error_o.
- MAX_BLOCKS=4, five beats without last → error_o on the 4th handshake.
- reset_i asserted during MSG_RUN → all outputs 0 the same cycle; a new start completes normally.
